// File: rtl/tdm_rx_pkg.sv
// Shared types and sizing helpers for the TDM burst receiver.
package tdm_rx_pkg;

  // Default geometry of the burst link.
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_BURST_LEN    = 4;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_FRAME_LEN    = DEF_NUM_CHANNELS * DEF_BURST_LEN;

  // Counter width able to index n positions; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int SLOT_W = cnt_width(DEF_FRAME_LEN);
  localparam int CHAN_W = cnt_width(DEF_NUM_CHANNELS);

  // Frame alignment states.
  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } rx_state_e;

  // One demultiplexed word as it sits in the output queue.
  typedef struct packed {
    logic [CHAN_W-1:0]         chan;
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } tdm_word_t;

endpackage

// File: rtl/tdm_rx_fifo.sv
// First-word-fall-through FIFO with same-cycle push and pop.
module tdm_rx_fifo
  import tdm_rx_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_width(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head word is forced to zero while empty so the outputs read zero after reset.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, otherwise a latch is inferred.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; validity is tracked by count_q, so stale contents are never seen.
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/tdm_burst_rx.sv
// Receive-side TDM burst demultiplexer: frame alignment, channel filter and output queue.
module tdm_burst_rx
  import tdm_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            din_valid,
  input  logic                            frame_sync,
  input  logic [NUM_CHANNELS-1:0]         chan_en,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [$clog2(NUM_CHANNELS)-1:0] m_chan,
  output logic                            m_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            locked,
  output logic                            sync_err,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int FRAME_LEN = NUM_CHANNELS * BURST_LEN;
  localparam int SLOT_BITS = cnt_width(FRAME_LEN);
  localparam int CHAN_BITS = $clog2(NUM_CHANNELS);
  localparam int WORD_W    = CHAN_BITS + 1 + DATA_WIDTH;

  localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(FRAME_LEN - 1);
  localparam logic [SLOT_BITS-1:0] BURST     = SLOT_BITS'(BURST_LEN);

  rx_state_e            state_q, state_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic                 sync_err_q, sync_err_d;
  logic                 overflow_q, overflow_d;

  logic                 proc_vld;
  logic [SLOT_BITS-1:0] proc_slot;
  logic [CHAN_BITS-1:0] proc_chan;
  logic                 proc_last;
  logic                 keep;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORD_W-1:0]    fifo_rdata;

  // Alignment decision for the current word: which slot it occupies and whether it is kept.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    sync_err_d = 1'b0;
    proc_vld   = 1'b0;
    proc_slot  = slot_q;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            proc_vld  = 1'b1;
            proc_slot = '0;
            state_d   = SYNC;
          end
        end
        SYNC: begin
          if (slot_q == '0 && !frame_sync) begin
            // Expected frame start is missing: alignment is lost.
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            proc_vld = 1'b1;
            if (frame_sync && slot_q != '0) begin
              // Early frame start: realign onto this word.
              sync_err_d = 1'b1;
              proc_slot  = '0;
            end
          end
        end
      endcase
      if (proc_vld) begin
        slot_d = (proc_slot == LAST_SLOT) ? '0 : proc_slot + SLOT_BITS'(1);
      end
    end
  end

  // Channel/beat of the processed slot and the queue hand-off.
  assign proc_chan = CHAN_BITS'(proc_slot / BURST);
  assign proc_last = ((proc_slot % BURST) == (BURST - SLOT_BITS'(1)));
  assign keep      = proc_vld && chan_en[proc_chan];
  assign pop       = !fifo_empty && m_ready;
  assign push      = keep && (!fifo_full || pop);

  // Sticky overflow: a new drop wins over a simultaneous clear.
  always_comb begin
    overflow_d = (overflow_q && !ovf_clr) || (keep && !push);
  end

  // Alignment state, slot counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

  tdm_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({proc_chan, proc_last, din}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {m_chan, m_last, m_data} = fifo_rdata;
  assign m_valid  = !fifo_empty;
  assign locked   = (state_q == SYNC);
  assign sync_err = sync_err_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tdm_burst_rx.sv
// Self-checking bench for tdm_burst_rx against a frame-position reference model.
module tb_tdm_burst_rx;
  import tdm_rx_pkg::*;

  localparam int DW    = DEF_DATA_WIDTH;
  localparam int NCH   = DEF_NUM_CHANNELS;
  localparam int BL    = DEF_BURST_LEN;
  localparam int DEPTH = DEF_FIFO_DEPTH;
  localparam int FLEN  = NCH * BL;

  logic              clk;
  logic              rst;
  logic [DW-1:0]     din;
  logic              din_valid;
  logic              frame_sync;
  logic [NCH-1:0]    chan_en;
  logic [DW-1:0]     m_data;
  logic [CHAN_W-1:0] m_chan;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic              locked;
  logic              sync_err;
  logic              overflow;
  logic              ovf_clr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: expected queue contents, frame position (-1 while hunting) and flags.
  tdm_word_t mq[$];
  int        pos   = -1;
  bit        m_err = 1'b0;
  bit        m_ovf = 1'b0;

  tdm_burst_rx #(
    .DATA_WIDTH   (DW),
    .NUM_CHANNELS (NCH),
    .BURST_LEN    (BL),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .chan_en    (chan_en),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .locked     (locked),
    .sync_err   (sync_err),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pos   = -1;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Compare every output against the model's current view.
  task automatic compare_outputs();
    tdm_word_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    check("m_valid",  32'(m_valid),  32'(mq.size() != 0));
    check("m_data",   32'(m_data),   32'(h.data));
    check("m_chan",   32'(m_chan),   32'(h.chan));
    check("m_last",   32'(m_last),   32'(h.last));
    check("locked",   32'(locked),   32'(pos >= 0));
    check("sync_err", 32'(sync_err), 32'(m_err));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit        do_pop;
    bit        proc;
    bit        drop;
    int        ps;
    tdm_word_t w;
    if (rst) begin
      model_reset();
      return;
    end
    do_pop = (mq.size() > 0) && m_ready;
    proc   = 1'b0;
    drop   = 1'b0;
    ps     = 0;
    m_err  = 1'b0;
    if (din_valid) begin
      if (pos < 0) begin
        if (frame_sync) begin
          proc = 1'b1;
          ps   = 0;
        end
      end else if (pos == 0 && !frame_sync) begin
        m_err = 1'b1;
        pos   = -1;
      end else begin
        proc = 1'b1;
        ps   = frame_sync ? 0 : pos;
        if (frame_sync && pos != 0) m_err = 1'b1;
      end
      if (proc) pos = (ps + 1) % FLEN;
    end
    if (do_pop) void'(mq.pop_front());
    if (proc && chan_en[ps / BL]) begin
      w.chan = CHAN_W'(ps / BL);
      w.last = ((ps % BL) == BL - 1);
      w.data = din;
      if (mq.size() < DEPTH) mq.push_back(w);
      else drop = 1'b1;
    end
    m_ovf = (m_ovf && !ovf_clr) || drop;
  endtask

  // One clock: apply inputs, check outputs on the falling edge, step the model.
  task automatic tick(input bit v, input logic [DW-1:0] d, input bit fs);
    din_valid  = v;
    din        = d;
    frame_sync = fs;
    @(negedge clk);
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    int ts;
    bit v;
    bit fs;
    bit slow;
    rst        = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    chan_en    = 4'hF;
    m_ready    = 1'b1;
    ovf_clr    = 1'b0;
    #2;
    async_reset();

    // Aligned frame, all channels enabled, consumer always ready.
    for (int i = 0; i < FLEN; i++) tick(1'b1, 8'(i), i == 0);
    idle(3);
    check("locked_after_frame", 32'(locked), 32'd1);

    // Same frame with only channels 0 and 2 enabled.
    chan_en = 4'b0101;
    for (int i = 0; i < FLEN; i++) tick(1'b1, 8'(i), i == 0);
    idle(3);

    // Stalled consumer: queue fills, 17th word overflows, clear, then drain.
    chan_en = 4'hF;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick(1'b1, 8'(i), (i % FLEN) == 0);
    check("ovf_after_fill", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_after_clr", 32'(overflow), 32'd0);
    m_ready = 1'b1;
    idle(DEPTH + 2);

    // Missing frame sync at slot 0: error, hunt, drop until next sync.
    for (int i = 4; i < FLEN; i++) tick(1'b1, 8'(8'h30 + i), 1'b0);
    tick(1'b1, 8'hA0, 1'b0);
    check("lost_lock", 32'(locked), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'hA1 + i), 1'b0);
    for (int i = 0; i < FLEN; i++) tick(1'b1, 8'(8'h40 + i), i == 0);
    idle(3);

    // Early frame sync at slot 6 while locked: realign.
    for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h50 + i), i == 0);
    for (int i = 0; i < FLEN; i++) tick(1'b1, 8'(8'h60 + i), i == 0);
    idle(3);

    // Gapped words, reset mid-burst at slot 5, then relock with gaps.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'(8'h70 + i), i == 0);
      if (i < 5) idle(3);
    end
    async_reset();
    m_ready = 1'b1;
    for (int i = 0; i < FLEN; i++) begin
      tick(1'b1, 8'(8'h80 + i), i == 0);
      idle(3);
    end
    check("relocked", 32'(locked), 32'd1);

    // Randomized traffic with occasional sync corruption, stalls and clears.
    ts   = 0;
    slow = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) slow = ~slow;
      v  = ($urandom_range(0, 3) != 0);
      fs = v && (ts == 0);
      if (v && $urandom_range(0, 49) == 0) fs = ~fs;
      m_ready = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      chan_en = 4'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick(v, 8'($urandom), fs);
      if (v) ts = (ts + 1) % FLEN;
    end
    ovf_clr = 1'b0;
    m_ready = 1'b1;
    idle(DEPTH + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
